rs7_5_encoder_serial: RTL and testbench

//  Symbol-serial systematic Reed-Solomon RS(7,5) encoder over GF(2^3), primitive poly x^3+x+1.

---
 rtl/rs7_5_encoder_serial_pkg.sv | 32 +++
 rtl/rs7_5_encoder_serial_if.sv | 27 ++
 rtl/rs7_5_encoder_serial_gf8_mul_const.sv | 14 +
 rtl/rs7_5_encoder_serial.sv | 96 +++++++++
 tb/tb_rs7_5_encoder_serial.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs7_5_encoder_serial_pkg.sv
// Shared GF(8) definitions for the lpGBT RS(7,5) encoder.
// Field is GF(2^3) with primitive polynomial x^3+x+1.
package lpgbt_rs_pkg;

  localparam int SYM_W    = 3;
  localparam int N_DATA   = 5;
  localparam int N_PARITY = 2;

  localparam logic [3:0] GF8_POLY = 4'b1011;
  localparam logic [2:0] G1 = 3'd6;
  localparam logic [2:0] G0 = 3'd3;

  typedef logic [2:0] sym_t;

  typedef enum logic {
    DATA,
    PAR
  } state_t;

  function automatic sym_t gf8_mul(sym_t a, sym_t b);
    sym_t p;
    sym_t t;
    p = '0;
    t = a;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[1:0], 1'b0} ^ (t[2] ? GF8_POLY[2:0] : 3'b000);
    end
    return p;
  endfunction

endpackage

// File: rtl/rs7_5_encoder_serial_if.sv
// Symbol handshake bundle for the RS(7,5) encoder.
// Upstream drives the master side, the encoder sits on the slave side.
interface rs7_5_encoder_serial_if;
  import lpgbt_rs_pkg::*;

  logic in_valid;
  logic in_ready;
  sym_t in_symbol;
  logic out_valid;
  logic out_ready;
  sym_t out_symbol;
  logic out_first;
  logic out_last;

  modport master (
    output in_valid, in_symbol, out_ready,
    input  in_ready, out_valid, out_symbol,
    input  out_first, out_last
  );

  modport slave (
    input  in_valid, in_symbol, out_ready,
    output in_ready, out_valid, out_symbol,
    output out_first, out_last
  );

endinterface

// File: rtl/rs7_5_encoder_serial_gf8_mul_const.sv
// Combinational GF(8) multiply by a constant.
// Folds into a pure XOR network once K is fixed.
module gf8_mul_const
  import lpgbt_rs_pkg::*;
#(
  parameter sym_t K = 3'd1
) (
  input  sym_t a,
  output sym_t y
);

  assign y = gf8_mul(a, K);

endmodule

// File: rtl/rs7_5_encoder_serial.sv
// Symbol-serial systematic RS(7,5) encoder over GF(8).
// Forwards 5 data symbols, then appends parity P1, P0.
module rs7_5_encoder_serial
  import lpgbt_rs_pkg::*;
#(
  parameter int SYM_W    = 3,
  parameter int N_DATA   = 5,
  parameter int N_PARITY = 2
) (
  input logic clk,
  input logic rst_n,
  rs7_5_encoder_serial_if.slave bus
);

  if (SYM_W != 3) begin : g_bad_sym_w
    $error("rs7_5_encoder_serial: SYM_W must be 3");
  end

  state_t state;
  logic [2:0] idx;
  logic pidx;
  sym_t r1, r0;
  sym_t f, f_g1, f_g0;
  logic adv, in_xfer;

  logic ov, ofirst, olast;
  sym_t osym;

  assign adv = !ov || bus.out_ready;
  assign bus.in_ready = (state == DATA) && adv;
  assign in_xfer = bus.in_valid && bus.in_ready;

  assign f = bus.in_symbol ^ r1;

  gf8_mul_const #(.K(G1)) u_mul_g1 (.a(f), .y(f_g1));
  gf8_mul_const #(.K(G0)) u_mul_g0 (.a(f), .y(f_g0));

  assign bus.out_valid  = ov;
  assign bus.out_symbol = osym;
  assign bus.out_first  = ofirst;
  assign bus.out_last   = olast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= DATA;
      idx    <= '0;
      pidx   <= 1'b0;
      r1     <= '0;
      r0     <= '0;
      ov     <= 1'b0;
      ofirst <= 1'b0;
      olast  <= 1'b0;
      osym   <= '0;
    end else begin
      unique case (state)
        DATA: begin
          if (in_xfer) begin
            r1     <= r0 ^ f_g1;
            r0     <= f_g0;
            osym   <= bus.in_symbol;
            ov     <= 1'b1;
            ofirst <= (idx == 3'd0);
            olast  <= 1'b0;
            if (idx == 3'(N_DATA - 1)) begin
              state <= PAR;
              pidx  <= 1'b0;
            end else begin
              idx <= idx + 3'd1;
            end
          end else if (adv) begin
            ov <= 1'b0;
          end
        end
        PAR: begin
          if (adv) begin
            // Parity leaves MSB first; the LFSR shifts toward r1.
            osym   <= r1;
            r1     <= r0;
            r0     <= '0;
            ov     <= 1'b1;
            ofirst <= 1'b0;
            olast  <= (pidx == 1'(N_PARITY - 1));
            if (pidx == 1'(N_PARITY - 1)) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              pidx <= pidx + 1'b1;
            end
          end
        end
        default: state <= DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_rs7_5_encoder_serial.sv
// Self-checking bench for the RS(7,5) serial encoder.
// Model: polynomial division and syndromes via GF(8) log/antilog.
module tb_rs7_5_encoder_serial;

  logic clk;
  logic rst_n;

  rs7_5_encoder_serial_if bus ();

  rs7_5_encoder_serial dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input bit ok, input string name,
                     input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int alog(input int e);
    int v;
    v = 1;
    for (int i = 0; i < (e % 7); i++) begin
      v = v << 1;
      if (v & 8) v = v ^ 11;
    end
    return v;
  endfunction

  function automatic int glog(input int x);
    for (int i = 0; i < 7; i++)
      if (alog(i) == x) return i;
    return -1;
  endfunction

  function automatic int gm(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog(glog(a) + glog(b));
  endfunction

  // Remainder of m(x)*x^2 divided by x^2+6x+3; returns {P1,P0}.
  function automatic logic [5:0] parity(input int m0, input int m1,
                                        input int m2, input int m3,
                                        input int m4);
    int c[7];
    c[0] = m0; c[1] = m1; c[2] = m2; c[3] = m3; c[4] = m4;
    c[5] = 0;  c[6] = 0;
    for (int i = 0; i < 5; i++) begin
      int q;
      q = c[i];
      c[i] = 0;
      c[i+1] = c[i+1] ^ gm(q, 6);
      c[i+2] = c[i+2] ^ gm(q, 3);
    end
    return {c[5][2:0], c[6][2:0]};
  endfunction

  logic [2:0] dq[$];
  logic [2:0] exp_q[$];
  logic [2:0] cw[$];
  int acc_in, out_xf, cyc;
  int log_v[$];
  int log_c[$];
  bit prev_stall;
  logic [5:0] prev_vec;
  bit stall_mode = 0;
  bit gaps = 0;

  always @(negedge clk) begin
    logic [5:0] cur;
    cyc++;
    cur = {bus.out_valid, bus.out_first, bus.out_last, bus.out_symbol};
    if (!rst_n) begin
      chk(cur == 6'd0, "reset_outputs", int'(cur), 0);
      dq.delete(); exp_q.delete(); cw.delete();
      acc_in = 0; out_xf = 0; prev_stall = 0;
    end else begin
      int reg_cnt;
      bit in_par, exp_rdy;
      if (prev_stall)
        chk(cur == prev_vec, "stall_hold", int'(cur), int'(prev_vec));
      reg_cnt = out_xf + int'(bus.out_valid);
      in_par = acc_in > 0 && acc_in % 5 == 0 && reg_cnt < acc_in / 5 * 7;
      exp_rdy = !in_par && (!bus.out_valid || bus.out_ready);
      chk(bus.in_ready == exp_rdy, "in_ready",
          int'(bus.in_ready), int'(exp_rdy));
      if (bus.out_valid && bus.out_ready) begin
        int pos;
        pos = out_xf % 7;
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_out", int'(bus.out_symbol), -1);
        end else begin
          logic [2:0] e;
          logic [4:0] got, want;
          e = exp_q.pop_front();
          got = {bus.out_first, bus.out_last, bus.out_symbol};
          want = {pos == 0, pos == 6, e};
          chk(got == want, "out_symbol", int'(got), int'(want));
        end
        log_v.push_back(int'({bus.out_first, bus.out_last, bus.out_symbol}));
        log_c.push_back(cyc);
        cw.push_back(bus.out_symbol);
        if (pos == 6) begin
          int s1, s2;
          s1 = 0; s2 = 0;
          for (int i = 0; i < 7; i++) begin
            s1 = s1 ^ gm(int'(cw[i]), alog(6 - i));
            s2 = s2 ^ gm(int'(cw[i]), alog(2 * (6 - i)));
          end
          chk(s1 == 0 && s2 == 0, "syndrome", s1 * 8 + s2, 0);
          cw.delete();
        end
        out_xf++;
      end
      if (bus.in_valid && bus.in_ready) begin
        dq.push_back(bus.in_symbol);
        exp_q.push_back(bus.in_symbol);
        acc_in++;
        if (dq.size() == 5) begin
          logic [5:0] p;
          p = parity(dq[0], dq[1], dq[2], dq[3], dq[4]);
          exp_q.push_back(p[5:3]);
          exp_q.push_back(p[2:0]);
          dq.delete();
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_vec = cur;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = stall_mode ? ($urandom_range(2) != 0) : 1'b1;
    end
  end

  task automatic put(input logic [2:0] s);
    int k;
    bit ok;
    k = 0;
    if (gaps && $urandom_range(3) == 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_symbol = s;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!ok && k < 100);
    if (!ok) chk(0, "in_timeout", 0, 1);
  endtask

  task automatic send(input int a, input int b, input int c,
                      input int d, input int e);
    put(3'(a)); put(3'(b)); put(3'(c)); put(3'(d)); put(3'(e));
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int w[7]);
    bit ok;
    ok = log_v.size() == 7;
    for (int i = 0; i < 7 && ok; i++)
      if ((log_v[i] & 7) != (w[i] & 7)) ok = 0;
    chk(ok, {name, "_seq"}, log_v.size() > 6 ? log_v[6] : -1, w[6]);
    ok = log_v.size() == 7;
    for (int i = 0; i < 7 && ok; i++)
      if (log_v[i] != w[i]) ok = 0;
    chk(ok, {name, "_flags"}, log_v.size() > 0 ? log_v[0] : -1, w[0]);
  endtask

  task automatic check_gapless(input string name, input int n);
    bit ok;
    ok = log_c.size() == n;
    for (int i = 1; i < log_c.size() && ok; i++)
      if (log_c[i] != log_c[0] + i) ok = 0;
    chk(ok, name, log_c.size(), n);
  endtask

  // {first,last,sym} per codeword slot
  int w1[7] = '{17, 0, 0, 0, 0, 6, 10};
  int w2[7] = '{16, 0, 0, 0, 1, 6, 11};
  int wz[7] = '{16, 0, 0, 0, 0, 0, 8};

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_symbol = '0;
    chk(parity(1, 0, 0, 0, 0) == {3'd6, 3'd2}, "model_p1",
        int'(parity(1, 0, 0, 0, 0)), 50);
    chk(parity(0, 0, 0, 0, 1) == {3'd6, 3'd3}, "model_p2",
        int'(parity(0, 0, 0, 0, 1)), 51);
    chk(parity(0, 0, 0, 0, 0) == 6'd0, "model_p0",
        int'(parity(0, 0, 0, 0, 0)), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    log_v.delete(); log_c.delete();
    send(1, 0, 0, 0, 0);
    drain();
    check_log("t1", w1);
    check_gapless("t1_gapless", 7);

    log_v.delete(); log_c.delete();
    send(0, 0, 0, 0, 1);
    drain();
    check_log("t2", w2);

    log_v.delete(); log_c.delete();
    send(0, 0, 0, 0, 0);
    drain();
    check_log("t2_zero", wz);

    stall_mode = 1;
    log_v.delete(); log_c.delete();
    send(1, 0, 0, 0, 0);
    drain();
    check_log("t3_stall", w1);
    stall_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    log_v.delete(); log_c.delete();
    send(1, 0, 0, 0, 0);
    send(0, 0, 0, 0, 1);
    drain();
    check_gapless("t4_gapless", 14);
    chk(log_v.size() == 14 && log_v[12] == 6 && log_v[13] == 11,
        "t4_second_parity",
        log_v.size() == 14 ? log_v[13] : -1, 11);

    send(5, 6, 7, 0, 0);
    drain();
    put(3'd4); put(3'd2); put(3'd7);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_v.delete(); log_c.delete();
    send(0, 0, 0, 0, 1);
    drain();
    check_log("t5_reset", w2);

    stall_mode = 1;
    gaps = 1;
    for (int n = 0; n < 1000; n++)
      send($urandom_range(7), $urandom_range(7), $urandom_range(7),
           $urandom_range(7), $urandom_range(7));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
